regfile_wb_scheduler: RTL

Owns the single write port of the 31×32-bit integer register file, which has x0 hard-wired to zero and no write-side arbitration of its own. Round-robin arbitrates up to NUM_REQ writeback producers (ALU, LSU, MULDIV, CSR) onto that port through one registered stage. Keeps a per-register busy scoreboard, set by issue reservations and cleared on write commit, so decode can stall on RAW/WAW hazards.

---
 rtl/regfile_wb_scheduler_pkg.sv | 21 ++
 rtl/regfile_wb_scheduler_rr_arbiter.sv | 36 +++
 rtl/regfile_wb_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared definitions for the register-file writeback scheduler.
// Holds default sizes, requester index assignments and the round-robin
// pointer advance helper.
package regfile_wb_scheduler_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned AW_DEF      = 5;

    // Fixed requester slots on the writeback port.
    localparam int unsigned REQ_ALU    = 0;
    localparam int unsigned REQ_LSU    = 1;
    localparam int unsigned REQ_MULDIV = 2;
    localparam int unsigned REQ_CSR    = 3;

    // Index following idx in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i   - request vector, one bit per requester
//   ptr_i   - highest-priority requester index this cycle
//   gnt_o   - one-hot grant (all zero when nothing requests)
//   idx_o   - encoded index of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Walk ptr, ptr+1, ... (mod NUM_REQ) and take the first active request.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((32'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = cand;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for the integer register file.
// Arbitrates NUM_REQ writeback producers onto the single register-file write
// port through one output register, and tracks a per-register busy scoreboard
// (set by decode reservations, cleared when the write commits).
// Ports:
//   clk, rst                       - clock, async active-high reset
//   rsv_valid/rsv_rd/rsv_ready     - destination reservation from decode
//   rs1_addr/rs2_addr, rs*_busy    - combinational hazard queries
//   req_valid/req_rd/req_data      - packed per-requester writeback requests
//   req_ready                      - one-hot combinational grant
//   wb_we/wb_rd/wb_data            - register-file write port
//   err_unres                      - sticky: write to an unreserved register
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned AW      = AW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rsv_valid,
    input  logic [AW-1:0]           rsv_rd,
    output logic                    rsv_ready,
    input  logic [AW-1:0]           rs1_addr,
    input  logic [AW-1:0]           rs2_addr,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*AW-1:0]   req_rd,
    input  logic [NUM_REQ*XLEN-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    wb_we,
    output logic [AW-1:0]           wb_rd,
    output logic [XLEN-1:0]         wb_data,
    output logic                    err_unres
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned N_REGS = 1 << AW;

    logic [N_REGS-1:0] busy_q, busy_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              wb_we_q, wb_we_d;
    logic [AW-1:0]     wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              err_q, err_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               xfer;
    logic [AW-1:0]      sel_rd;
    logic [XLEN-1:0]    sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign xfer      = |gnt;
    assign req_ready = gnt;

    // Mux the granted requester's address and data.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_rd   = req_rd[i*AW +: AW];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    assign rsv_ready = (rsv_rd == '0) | ~busy_q[rsv_rd];
    assign rs1_busy  = busy_q[rs1_addr];
    assign rs2_busy  = busy_q[rs2_addr];

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wb_we_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        err_d     = err_q;
        busy_d    = busy_q;

        if (xfer) begin
            rr_ptr_d = IDX_W'(rr_next(32'(gnt_idx), NUM_REQ));
            // rd=0 releases the requester but never reaches the file.
            if (sel_rd != '0) begin
                wb_we_d   = 1'b1;
                wb_rd_d   = sel_rd;
                wb_data_d = sel_data;
                if (!busy_q[sel_rd]) begin
                    err_d = 1'b1;
                end
            end
        end

        // Commit clears first so a same-edge reservation of the same register wins.
        if (wb_we_q) begin
            busy_d[wb_rd_q] = 1'b0;
        end
        if (rsv_valid && rsv_ready && (rsv_rd != '0)) begin
            busy_d[rsv_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= '0;
            rr_ptr_q  <= '0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            rr_ptr_q  <= rr_ptr_d;
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
        end
    end

    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign err_unres = err_q;

endmodule
